mem_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares the single 4096-word unified memory between the instruction-fetch path (port 0) and the load/store path (port 1) of the multi-cycle CPU. It sits between the controller/datapath and the memory. It accepts level requests and grants them round-robin. It drives the memory's read-enable, write-enable, address and write-data for exactly one access cycle, then returns read data with a one-cycle acknowledge. Out-of-range addresses complete with an error flag and never reach the memory.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arbiter_rr_arb2.sv | 22 ++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state type and constants for the two-port
// unified-memory arbiter (fetch port 0, load/store port 1).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;
    localparam int   MEM_DEPTH  = 4096;
    localparam int   IDX_W      = $clog2(MEM_DEPTH);

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-request round-robin grant.
// On a tie the port that did not win last time is chosen.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt_valid,
    output logic gnt_idx
);

    // Lone requester wins; on a tie, alternate away from last_gnt
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_idx   = 1'b0;
        if (req0 && req1) begin
            gnt_idx = ~last_gnt;
        end else if (req1) begin
            gnt_idx = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified memory between fetch and load/store,
// sequencing each grant through a single access cycle and an ack cycle.
module mem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = mem_arb_pkg::IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import mem_arb_pkg::*;

    state_t            state;
    logic              last_gnt;
    logic              port;
    logic              gnt_valid;
    logic              gnt_idx;
    logic              sel_we;
    logic              sel_ok;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 u_rr (
        .req0      (req0),
        .req1      (req1),
        .last_gnt  (last_gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Pick the winning port's request fields and range-check its address
    always_comb begin
        sel_we    = gnt_idx ? we1 : we0;
        sel_addr  = gnt_idx ? addr1 : addr0;
        sel_wdata = gnt_idx ? wdata1 : wdata0;
        sel_ok    = (sel_addr[ADDR_W-1:IDX_W] == '0);
    end

    // Sequencer: grant in IDLE, one memory strobe cycle, then a one-cycle ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_gnt  <= PORT_DATA;
            port      <= PORT_FETCH;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        port     <= gnt_idx;
                        last_gnt <= gnt_idx;
                        if (sel_ok) begin
                            state     <= ACCESS;
                            mem_read  <= ~sel_we;
                            mem_write <= sel_we;
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_wdata;
                        end else begin
                            // Bad address: complete at once, memory untouched
                            state <= DONE;
                            ack0  <= (gnt_idx == PORT_FETCH);
                            ack1  <= (gnt_idx == PORT_DATA);
                            err0  <= (gnt_idx == PORT_FETCH);
                            err1  <= (gnt_idx == PORT_DATA);
                        end
                    end
                end
                ACCESS: begin
                    if (mem_read) begin
                        if (port == PORT_FETCH) begin
                            rdata0 <= mem_rdata;
                        end else begin
                            rdata1 <= mem_rdata;
                        end
                    end
                    state     <= DONE;
                    ack0      <= (port == PORT_FETCH);
                    ack1      <= (port == PORT_DATA);
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                end
                DONE: begin
                    state <= IDLE;
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    err0  <= 1'b0;
                    err1  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized two-port traffic,
// checked against a transaction-level arbitration and memory model.
module tb_mem_arbiter;

    import mem_arb_pkg::*;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rq   [2];
    logic        rwe  [2];
    logic [31:0] radr [2];
    logic [31:0] rwd  [2];
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [MEM_DEPTH];
    logic        pl_en = 1'b0;
    logic [11:0] pl_idx = '0;
    logic [31:0] pl_val = '0;

    int          n_tests = 0;
    int          n_fail  = 0;

    // model state
    int          cyc, next_free, acc_cyc, ack_cyc;
    logic        m_last, a_port, a_we, a_err;
    logic [31:0] a_addr, a_wdata, pend_rd;
    logic [31:0] ref_mem [MEM_DEPTH];
    logic [31:0] m_rdata [2];
    txn_t        q0[$], q1[$];
    bit          rand_en = 0;
    int          log_cyc[$], log_port[$];
    int          rd_cnt;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (rq[0]),
        .req1      (rq[1]),
        .we0       (rwe[0]),
        .we1       (rwe[1]),
        .addr0     (radr[0]),
        .addr1     (radr[1]),
        .wdata0    (rwd[0]),
        .wdata1    (rwd[1]),
        .ack0      (ack0),
        .ack1      (ack1),
        .err0      (err0),
        .err1      (err1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // unified memory: falling-edge writes, combinational reads
    always @(negedge clk) begin
        if (mem_write) mem[mem_addr[11:0]] <= mem_wdata;
        if (pl_en) mem[pl_idx] <= pl_val;
    end
    assign mem_rdata = mem[mem_addr[11:0]];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic txn_t mk(logic we, logic [31:0] addr,
                                logic [31:0] wdata);
        txn_t t;
        t.we    = we;
        t.addr  = addr;
        t.wdata = wdata;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.we    = 1'($urandom_range(0, 1));
        t.wdata = $urandom;
        if ($urandom_range(0, 7) == 0)
            t.addr = (32'h1000 << $urandom_range(0, 19))
                   | 32'($urandom_range(0, 4095));
        else
            t.addr = 32'($urandom_range(0, 31));
        return t;
    endfunction

    task automatic preload(int idx, logic [31:0] v);
        rst    = 1'b1;
        pl_idx = idx[11:0];
        pl_val = v;
        pl_en  = 1'b1;
        @(negedge clk);
        #1 pl_en = 1'b0;
        ref_mem[idx] = v;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        rq[0] = 1'b0;
        rq[1] = 1'b0;
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        cyc       = 0;
        next_free = 0;
        acc_cyc   = -100;
        ack_cyc   = -100;
        m_last    = 1'b1;
        a_port    = 1'b0;
        a_we      = 1'b0;
        a_err     = 1'b0;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        rd_cnt    = 0;
        log_cyc.delete();
        log_port.delete();
    endtask

    // compare this cycle's outputs with what the model scheduled
    task automatic check_cycle();
        logic in_acc, e_rd, e_wr, e_a0, e_a1, e_e0, e_e1;
        in_acc = (cyc == acc_cyc);
        if (in_acc) begin
            if (a_we) ref_mem[a_addr[11:0]] = a_wdata;
            else pend_rd = ref_mem[a_addr[11:0]];
        end
        if (cyc == ack_cyc && !a_err && !a_we) m_rdata[a_port] = pend_rd;
        e_rd = in_acc && !a_we;
        e_wr = in_acc && a_we;
        e_a0 = (cyc == ack_cyc) && (a_port == 1'b0);
        e_a1 = (cyc == ack_cyc) && (a_port == 1'b1);
        e_e0 = e_a0 && a_err;
        e_e1 = e_a1 && a_err;
        chk("ctl", 32'({ack1, ack0, err1, err0, mem_read, mem_write}),
                   32'({e_a1, e_a0, e_e1, e_e0, e_rd, e_wr}));
        chk("mem_addr", mem_addr, in_acc ? a_addr : 32'd0);
        chk("mem_wdata", mem_wdata, in_acc ? a_wdata : 32'd0);
        chk("rdata0", rdata0, m_rdata[0]);
        chk("rdata1", rdata1, m_rdata[1]);
        if (mem_read) rd_cnt++;
        if (ack0) begin log_cyc.push_back(cyc); log_port.push_back(0); end
        if (ack1) begin log_cyc.push_back(cyc); log_port.push_back(1); end
    endtask

    // requesters: hold a request until its ack, then take the next one
    task automatic update_reqs();
        logic got [2];
        txn_t t;
        bit   have;
        got[0] = ack0;
        got[1] = ack1;
        for (int p = 0; p < 2; p++) begin
            if (rq[p] && got[p]) rq[p] = 1'b0;
            if (!rq[p]) begin
                have = 0;
                t    = '0;
                if (p == 0 && q0.size() > 0) begin
                    t = q0.pop_front(); have = 1;
                end else if (p == 1 && q1.size() > 0) begin
                    t = q1.pop_front(); have = 1;
                end else if (rand_en && $urandom_range(0, 2) != 0) begin
                    t = rand_txn(); have = 1;
                end
                if (have) begin
                    rq[p]   = 1'b1;
                    rwe[p]  = t.we;
                    radr[p] = t.addr;
                    rwd[p]  = t.wdata;
                end
            end
        end
    endtask

    // arbitration model: decide who is granted at the coming edge
    task automatic decide();
        int   p;
        logic ok;
        if (cyc < next_free || !(rq[0] || rq[1])) return;
        if (rq[0] && rq[1]) p = m_last ? 0 : 1;
        else p = rq[1] ? 1 : 0;
        m_last  = p[0];
        ok      = radr[p] < MEM_DEPTH;
        a_port  = p[0];
        a_we    = rwe[p];
        a_addr  = radr[p];
        a_wdata = rwd[p];
        a_err   = !ok;
        if (ok) begin
            acc_cyc   = cyc + 1;
            ack_cyc   = cyc + 2;
            next_free = cyc + 3;
        end else begin
            acc_cyc   = -100;
            ack_cyc   = cyc + 1;
            next_free = cyc + 2;
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) begin
            check_cycle();
            update_reqs();
            decide();
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            rq[p] = 1'b0; rwe[p] = 1'b0; radr[p] = '0; rwd[p] = '0;
        end
        a_addr = '0; a_wdata = '0; pend_rd = '0;
        cyc = 0;
        for (int i = 0; i < 32; i++) preload(i, $urandom);
        preload(5, 32'hDEADBEEF);
        preload(7, 32'h0BADF00D);
        preload(100, 32'h0);

        // single read
        do_reset();
        q0.push_back(mk(1'b0, 32'd5, 32'd0));
        run(6);
        chk("rd_strobes", 32'(rd_cnt), 32'd1);
        chk("rd_data", rdata0, 32'hDEADBEEF);
        chk("rd_nack", 32'(log_cyc.size()), 32'd1);
        if (log_cyc.size() > 0) chk("rd_ack_cyc", 32'(log_cyc[0]), 32'd2);

        // write then read
        do_reset();
        q1.push_back(mk(1'b1, 32'd100, 32'h12345678));
        run(5);
        q0.push_back(mk(1'b0, 32'd100, 32'd0));
        run(5);
        chk("wr_rd", rdata0, 32'h12345678);

        // contention
        do_reset();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(1'b0, 32'(i), 32'd0));
            q1.push_back(mk(1'b0, 32'(i + 8), 32'd0));
        end
        run(20);
        chk("cont_nack", 32'(log_cyc.size()), 32'd6);
        for (int i = 0; i < log_cyc.size() && i < 6; i++) begin
            chk("cont_port", 32'(log_port[i]), 32'(i % 2));
            chk("cont_cyc", 32'(log_cyc[i]), 32'(2 + 3 * i));
        end

        // out of range after a good read
        do_reset();
        q1.push_back(mk(1'b0, 32'd5, 32'd0));
        q1.push_back(mk(1'b0, 32'h0000_1000, 32'd0));
        run(8);
        chk("oor_strobes", 32'(rd_cnt), 32'd1);
        chk("oor_rdata", rdata1, 32'hDEADBEEF);
        chk("oor_nack", 32'(log_cyc.size()), 32'd2);
        if (log_cyc.size() > 1) chk("oor_ack_cyc", 32'(log_cyc[1]), 32'd4);

        // reset during the access cycle of a write
        do_reset();
        q1.push_back(mk(1'b1, 32'd7, 32'hAAAA5555));
        run(1);
        chk("rst_in_acc", 32'(mem_write), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_ctl", 32'({ack0, ack1, err0, err1, mem_read, mem_write}), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", rdata0 | rdata1, 32'd0);
        rq[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 chk("rst_noack", 32'({ack0, ack1}), 32'd0);
        end
        chk("rst_mem7", mem[7], 32'h0BADF00D);

        // back-to-back on port 0 alone
        do_reset();
        for (int i = 0; i < 3; i++) q0.push_back(mk(1'b0, 32'(i + 1), 32'd0));
        run(12);
        chk("b2b_nack", 32'(log_cyc.size()), 32'd3);
        for (int i = 0; i < log_cyc.size() && i < 3; i++)
            chk("b2b_cyc", 32'(log_cyc[i]), 32'(2 + 3 * i));

        // random two-port traffic
        do_reset();
        rand_en = 1;
        run(800);
        rand_en = 0;
        run(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
